// File: rtl/zap_fetch_bus_if_pkg.sv
// Shared fetch-side definitions: FSM encodings, abort payload, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Imported by the Wishbone fetch interface and by the fetch stage, so both
// sides agree on the state encoding and on what an aborted fetch delivers.
package zap_fetch_bus_if_pkg;

  // 2-bit encodings are visible to the fetch stage when it decodes
  // debug taps, so they are pinned explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SLEEP = 2'd3
  } fetch_state_t;

  // Instruction word delivered alongside an abort indication.
  localparam logic [31:0] ABORT_PAYLOAD = 32'd0;

  // Fetches are always full 32-bit words.
  localparam logic [3:0]  WB_SEL_WORD   = 4'hF;

  // Drop the byte offset so every bus read is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/zap_fetch_bus_if_if.sv
// Wishbone classic read-only bus bundle between the fetch unit and memory.
// Latency: n/a (wiring only).
// Backpressure: slave stretches a cycle by withholding ack/err.
//
// Signals:
//   cyc, stb  cycle / strobe (master)
//   adr       word-aligned address (master)
//   sel, we   byte selects / write enable, fixed for reads (master)
//   dat       read data (slave)
//   ack, err  completion / bus error (slave)
interface zap_fetch_bus_if_if;

  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, adr, sel, we,
    input  dat, ack, err
  );

  modport slave (
    input  cyc, stb, adr, sel, we,
    output dat, ack, err
  );

endinterface

// File: rtl/zap_fetch_timeout_ctr.sv
// Watchdog counter for an outstanding fetch bus cycle (ZAP_FETCH_TIMEOUT_EN only).
// Latency: o_expired is combinational from the registered count.
// Backpressure: none; counts while i_en, restarts on i_clr.
//
// Ports:
//   i_clk, i_reset_n  clock, async active-low reset
//   i_en              count this cycle (fetch FSM is waiting on the bus)
//   i_clr             restart from zero (FSM changes state this cycle)
//   o_expired         count has reached LIMIT-1 while enabled
// The whole module is compiled only when ZAP_FETCH_TIMEOUT_EN is defined so a
// default build carries no stray top-level module. LIMIT must be at least 1.
`ifdef ZAP_FETCH_TIMEOUT_EN
module zap_fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned   W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a stuck slave cannot wrap the count back to zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign o_expired = i_en && (cnt == LAST);

endmodule
`endif

// File: rtl/zap_fetch_bus_if.sv
// Instruction fetch Wishbone master: one outstanding word read, registered result.
// Latency: o_valid 2 cycles after i_pc_ff is taken with a zero-wait slave.
// Backpressure: i_stall holds every output and blocks new requests; i_clear flushes.
//
// Ports:
//   i_clk, i_reset_n   clock, async active-low reset
//   i_clear            flush (overrides i_stall)
//   i_stall            downstream cannot accept
//   i_pc_ff            address of next instruction
//   wb                 Wishbone classic read master
//   o_instruction      fetched word (ABORT_PAYLOAD on abort)
//   o_valid            result fields are meaningful
//   o_instr_abort      fetch ended in bus error / timeout
//   o_pc               word address the result came from
// Optional feature macro: ZAP_FETCH_TIMEOUT_EN enables a TIMEOUT_CYCLES
// watchdog that turns a silent slave into an abort.
module zap_fetch_bus_if
  import zap_fetch_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clear,
  input  logic               i_stall,
  input  logic [31:0]        i_pc_ff,
  zap_fetch_bus_if_if.master wb,
  output logic [31:0]        o_instruction,
  output logic               o_valid,
  output logic               o_instr_abort,
  output logic [31:0]        o_pc
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic        cyc_d;
  logic        stb_d;
  logic [31:0] adr_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        abort_d;
  logic [31:0] pc_d;

  logic        to_hit;
  logic        bus_err;
  logic        bus_done;

  assign wb.sel = WB_SEL_WORD;
  assign wb.we  = 1'b0;

`ifdef ZAP_FETCH_TIMEOUT_EN
  logic to_en;
  logic to_clr;

  // Count only while waiting on the bus; any state change restarts the
  // count so DRAIN gets its own full window after leaving REQ.
  assign to_en  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign to_clr = (state_d != state_q);

  zap_fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (to_en),
    .i_clr     (to_clr),
    .o_expired (to_hit)
  );
`else
  // No watchdog: the bus may stall forever. TIMEOUT_CYCLES is still
  // referenced so both builds share one parameter list without lint noise.
  assign to_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // A timeout is indistinguishable from a slave error downstream.
  assign bus_err  = wb.err | to_hit;
  assign bus_done = wb.ack | bus_err;

  always_comb begin
    state_d = state_q;
    cyc_d   = wb.cyc;
    stb_d   = wb.stb;
    adr_d   = wb.adr;
    instr_d = o_instruction;
    valid_d = o_valid;
    abort_d = o_instr_abort;
    pc_d    = o_pc;

    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          instr_d = '0;
        end else if (!i_stall) begin
          // The held result (if any) is consumed this cycle, and the next
          // fetch goes out in the same cycle.
          valid_d = 1'b0;
          adr_d   = word_align(i_pc_ff);
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (i_clear) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          instr_d = '0;
          stb_d   = 1'b0;
          if (bus_done) begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // Keep cyc so the slave can finish; its response is dropped.
            state_d = ST_DRAIN;
          end
        end else if (bus_err) begin
          // Error takes precedence over a coincident ack.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          valid_d = 1'b1;
          abort_d = 1'b1;
          instr_d = ABORT_PAYLOAD;
          pc_d    = wb.adr;
          state_d = ST_SLEEP;
        end else if (wb.ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          valid_d = 1'b1;
          abort_d = 1'b0;
          instr_d = wb.dat;
          pc_d    = wb.adr;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (bus_done) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_SLEEP: begin
        // After an abort nothing is fetched until the pipeline flushes.
        if (i_clear) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          instr_d = '0;
          state_d = ST_IDLE;
        end else if (!i_stall) begin
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      wb.cyc        <= 1'b0;
      wb.stb        <= 1'b0;
      wb.adr        <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
      o_instr_abort <= 1'b0;
      o_pc          <= '0;
    end else begin
      state_q       <= state_d;
      wb.cyc        <= cyc_d;
      wb.stb        <= stb_d;
      wb.adr        <= adr_d;
      o_instruction <= instr_d;
      o_valid       <= valid_d;
      o_instr_abort <= abort_d;
      o_pc          <= pc_d;
    end
  end

endmodule

// File: tb/tb_zap_fetch_bus_if.sv
// Testbench for zap_fetch_bus_if: directed sequence with randomized addresses,
// data and wait states, checked against a word-memory model of the slave.
// Build with or without ZAP_FETCH_TIMEOUT_EN (timeout check adapts).
module tb_zap_fetch_bus_if;

  localparam int unsigned TO = 8;

  logic        i_clk     = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_clear   = 1'b0;
  logic        i_stall   = 1'b0;
  logic [31:0] i_pc_ff   = 32'd0;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic        o_instr_abort;
  logic [31:0] o_pc;

  zap_fetch_bus_if_if wb ();

  zap_fetch_bus_if #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clear       (i_clear),
    .i_stall       (i_stall),
    .i_pc_ff       (i_pc_ff),
    .wb            (wb),
    .o_instruction (o_instruction),
    .o_valid       (o_valid),
    .o_instr_abort (o_instr_abort),
    .o_pc          (o_pc)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Slave memory model: words are created on first touch.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cur_adr;     // expected bus address of the current fetch
  logic [31:0] last_instr;  // expected delivered word
  logic        last_abort;  // expected abort flag

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a PC with the DUT ready; one edge later the read must be on the bus.
  task automatic issue(input logic [31:0] pc, input string tag);
    i_pc_ff = pc;
    cur_adr = pc & 32'hFFFF_FFFC;
    step();
    chk({tag, ".cyc"},   wb.cyc,  1);
    chk({tag, ".stb"},   wb.stb,  1);
    chk({tag, ".adr"},   wb.adr,  cur_adr);
    chk({tag, ".valid"}, o_valid, 0);
  endtask

  // Slave: wait states, then ack and/or err; check the registered result.
  task automatic respond(input int waits, input bit ack, input bit err, input string tag);
    for (int w = 0; w < waits; w++) begin
      step();
      chk({tag, ".wait_cyc"},   wb.cyc,  1);
      chk({tag, ".wait_valid"}, o_valid, 0);
    end
    wb.ack = ack;
    wb.err = err;
    wb.dat = err ? $urandom : mem_word(wb.adr);
    last_instr = err ? 32'd0 : mem_word(cur_adr);
    last_abort = err;
    step();
    wb.ack = 1'b0;
    wb.err = 1'b0;
    chk({tag, ".valid"}, o_valid,       1);
    chk({tag, ".abort"}, o_instr_abort, last_abort);
    chk({tag, ".instr"}, o_instruction, last_instr);
    chk({tag, ".pc"},    o_pc,          cur_adr);
    chk({tag, ".cyc"},   wb.cyc,        0);
    chk({tag, ".stb"},   wb.stb,        0);
  endtask

  // Downstream stall with a result held: nothing may move.
  task automatic hold(input int n, input string tag);
    i_stall = 1'b1;
    for (int c = 0; c < n; c++) begin
      step();
      chk({tag, ".valid"}, o_valid,       1);
      chk({tag, ".instr"}, o_instruction, last_instr);
      chk({tag, ".abort"}, o_instr_abort, last_abort);
      chk({tag, ".pc"},    o_pc,          cur_adr);
      chk({tag, ".stb"},   wb.stb,        0);
    end
    i_stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    wb.dat = 32'd0;
    wb.ack = 1'b0;
    wb.err = 1'b0;
    mem[32'h100] = 32'hE3A0_0001;

    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst.cyc",   wb.cyc,        0);
    chk("rst.stb",   wb.stb,        0);
    chk("rst.adr",   wb.adr,        0);
    chk("rst.instr", o_instruction, 0);
    chk("rst.pc",    o_pc,          0);
    chk("rst.valid", o_valid,       0);
    chk("rst.abort", o_instr_abort, 0);
    chk("rst.sel",   wb.sel,        32'hF);
    chk("rst.we",    wb.we,         0);

    // Stalled in IDLE: no request
    i_stall   = 1'b1;
    i_pc_ff   = 32'h100;
    i_reset_n = 1'b1;
    step();
    step();
    chk("stall_idle.stb", wb.stb, 0);
    i_stall = 1'b0;

    // Basic fetch, zero wait
    issue(32'h100, "t032");
    respond(0, 1'b1, 1'b0, "t032");

    // Misaligned PC
    issue(32'h203, "t033");
    respond(1, 1'b1, 1'b0, "t033");

    // Random fetches with random wait states and occasional stalls
    for (int k = 0; k < 16; k++) begin
      issue($urandom, "rnd");
      respond(int'($urandom_range(0, 3)), 1'b1, 1'b0, "rnd");
      if ($urandom_range(0, 1) == 1) hold(int'($urandom_range(1, 3)), "rnd_hold");
    end

    // Stall for 4 cycles, then release -> next fetch
    issue($urandom, "t036");
    respond(0, 1'b1, 1'b0, "t036");
    hold(4, "t036_hold");
    issue($urandom, "t036_next");
    respond(0, 1'b1, 1'b0, "t036_next");

    // Bus error -> abort, sleep until clear
    issue(32'h400, "t034");
    respond(0, 1'b0, 1'b1, "t034");
    step();
    chk("t034.consumed", o_valid, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t034.sleep_stb", wb.stb, 0);
      chk("t034.sleep_cyc", wb.cyc, 0);
    end
    i_pc_ff = 32'h800;
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("t034.clr_valid", o_valid,       0);
    chk("t034.clr_abort", o_instr_abort, 0);
    chk("t034.clr_instr", o_instruction, 0);
    chk("t034.clr_stb",   wb.stb,        0);
    issue(32'h804, "t034_new");
    respond(2, 1'b1, 1'b0, "t034_new");

    // Simultaneous ack and err: error wins
    issue($urandom, "ackerr");
    respond(0, 1'b1, 1'b1, "ackerr");

    // Clear overrides stall while an abort is held
    i_stall = 1'b1;
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr_stall.valid", o_valid,       0);
    chk("clr_stall.abort", o_instr_abort, 0);
    chk("clr_stall.instr", o_instruction, 0);
    step();
    chk("clr_stall.no_req", wb.stb, 0);
    i_stall = 1'b0;
    issue($urandom, "after_clr");
    respond(0, 1'b1, 1'b0, "after_clr");

    // Clear in REQ, ack 3 cycles later is discarded
    issue($urandom, "t035");
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("t035.cyc",   wb.cyc,  1);
    chk("t035.stb",   wb.stb,  0);
    chk("t035.valid", o_valid, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t035.drain_cyc", wb.cyc, 1);
      chk("t035.drain_stb", wb.stb, 0);
    end
    wb.ack = 1'b1;
    wb.dat = $urandom;
    step();
    wb.ack = 1'b0;
    chk("t035.done_cyc",   wb.cyc,  0);
    chk("t035.done_valid", o_valid, 0);
    issue($urandom, "t035_next");
    respond(1, 1'b1, 1'b0, "t035_next");

    // Clear coincident with ack
    issue($urandom, "clr_ack");
    wb.ack  = 1'b1;
    wb.dat  = $urandom;
    i_clear = 1'b1;
    step();
    wb.ack  = 1'b0;
    i_clear = 1'b0;
    chk("clr_ack.cyc",   wb.cyc,        0);
    chk("clr_ack.stb",   wb.stb,        0);
    chk("clr_ack.valid", o_valid,       0);
    chk("clr_ack.instr", o_instruction, 0);
    issue($urandom, "clr_ack_next");
    respond(0, 1'b1, 1'b0, "clr_ack_next");

    // Silent slave
    issue($urandom, "t037");
`ifdef ZAP_FETCH_TIMEOUT_EN
    for (int c = 0; c < int'(TO) - 1; c++) begin
      step();
      chk("t037.wait_cyc",   wb.cyc,  1);
      chk("t037.wait_valid", o_valid, 0);
    end
    step();
    chk("t037.valid", o_valid,       1);
    chk("t037.abort", o_instr_abort, 1);
    chk("t037.instr", o_instruction, 0);
    chk("t037.pc",    o_pc,          cur_adr);
    chk("t037.cyc",   wb.cyc,        0);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("t037.clr_valid", o_valid, 0);
`else
    hi = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (wb.cyc === 1'b1 && wb.stb === 1'b1 && o_valid === 1'b0) hi++;
    end
    chk("t037.cyc_held", hi, 120);
    respond(0, 1'b1, 1'b0, "t037_late");
`endif

    // Asynchronous reset mid-transaction
    issue($urandom, "arst");
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst.cyc",   wb.cyc,        0);
    chk("arst.stb",   wb.stb,        0);
    chk("arst.adr",   wb.adr,        0);
    chk("arst.valid", o_valid,       0);
    chk("arst.instr", o_instruction, 0);
    chk("arst.pc",    o_pc,          0);
    #2;
    i_reset_n = 1'b1;
    issue($urandom, "arst_next");
    respond(0, 1'b1, 1'b0, "arst_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_fetch_bus_if.md
ZAP_FETCH_BUS_IF -- requirements
Module: zap_fetch_bus_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: bus cycles allowed before a request is forced to abort; used only under the timeout macro.
REQ-002 i_clk  in  1  ZAP clock; all state changes on rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_clear  in  1  flush request (writeback/ALU clear, OR-ed upstream); highest priority after reset.
REQ-005 i_stall  in  1  fetch stage cannot accept; OR of all downstream stalls.
REQ-006 i_pc_ff  in  32  address of next instruction to fetch.
REQ-007 o_wb_cyc, o_wb_stb  out  1 each  Wishbone classic read cycle/strobe.
REQ-008 o_wb_adr  out  32  word-aligned read address.
REQ-009 o_wb_sel  out  4  constant 4'hF; o_wb_we constant 0.
REQ-010 i_wb_dat  in  32  read data; i_wb_ack, i_wb_err  in  1 each  completion and bus error.
REQ-011 o_instruction  out  32  fetched word, or 32'd0 on abort.
REQ-012 o_valid  out  1  o_instruction/o_instr_abort/o_pc are meaningful.
REQ-013 o_instr_abort  out  1  instruction abort indication.
REQ-014 o_pc  out  32  address the delivered word was fetched from.

Function
REQ-015 States: IDLE, REQ, DRAIN, SLEEP. All outputs are registered.
REQ-016 IDLE: if !i_clear, !i_stall and no held output, the block SHALL latch {i_pc_ff[31:2],2'b00} into o_wb_adr, raise cyc/stb, and enter REQ.
REQ-017 REQ, i_wb_ack=1: next cycle o_valid=1, o_instruction=i_wb_dat, o_instr_abort=0, o_pc=o_wb_adr; cyc/stb drop; go to IDLE.
REQ-018 REQ, i_wb_err=1: next cycle o_valid=1, o_instr_abort=1, o_instruction=32'd0, o_pc=o_wb_adr; cyc/stb drop; go to SLEEP. Simultaneous ack and err: err wins.
REQ-019 Latency: with a zero-wait slave, o_valid rises 2 cycles after i_pc_ff is sampled in IDLE; one instruction is outstanding at most.
REQ-020 o_valid is a one-cycle pulse when i_stall=0; while i_stall=1, all outputs SHALL hold and no new request is issued.
REQ-021 SLEEP: no requests; o_valid=0 after the abort is consumed; exit only via i_clear.
REQ-022 i_clear in IDLE/SLEEP: outputs cleared next cycle (o_valid=0, o_instr_abort=0, o_instruction=0); go to IDLE.
REQ-023 i_clear in REQ without ack/err: go to DRAIN with stb dropped and cyc held; the eventual ack/err is discarded; then IDLE.
REQ-024 i_clear coincident with ack/err: response discarded, outputs cleared, go to IDLE.
REQ-025 i_clear overrides i_stall; the first request after a clear uses the current i_pc_ff.

Reset
REQ-026 Asynchronous assertion: state IDLE; o_wb_cyc/stb=0; o_wb_adr, o_instruction and o_pc=0; o_valid and o_instr_abort=0; timeout counter=0.
REQ-027 Reset mid-transaction abandons the bus cycle. Synchronous deassertion is the integrator's responsibility.

Configuration
REQ-028 Macro ZAP_FETCH_TIMEOUT_EN defined: a counter runs in REQ/DRAIN and clears on state entry. In REQ, reaching TIMEOUT_CYCLES-1 without ack/err is treated exactly as i_wb_err. In DRAIN, it returns to IDLE.
REQ-029 Macro undefined: no counter is present, and REQ/DRAIN wait indefinitely.

Structure
REQ-030 State encodings (2-bit) and ABORT_PAYLOAD=32'd0 go in the shared fetch defines include, also used by the fetch stage.
REQ-031 The timeout counter is sub-module zap_fetch_timeout_ctr, instantiated only under ZAP_FETCH_TIMEOUT_EN.

Verification
REQ-032 i_pc_ff=0x100, zero-wait ack with dat=0xE3A00001 -> adr=0x100; o_valid pulses 2 cycles later with o_instruction=0xE3A00001 and o_pc=0x100.
REQ-033 i_pc_ff=0x203 (misaligned) -> o_wb_adr=0x200.
REQ-034 i_wb_err on 0x400 -> o_valid=1, o_instr_abort=1, o_instruction=0; no further stb until i_clear; then a fetch occurs at the new i_pc_ff.
REQ-035 i_clear in REQ with ack arriving 3 cycles later -> cyc held until ack, no o_valid, next request from IDLE.
REQ-036 i_stall=1 for 4 cycles while o_valid=1 -> outputs stable, stb=0 throughout; stall release -> one-cycle pulse, then next fetch.
REQ-037 ZAP_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> abort after 8 cycles in REQ; without the macro -> cyc stays high for 100+ cycles.
